// File: rtl/instr_prefetch_pkg.sv
// Shared constants and types for the instruction prefetch stage.
//   PC_INIT_DEFAULT : fetch PC after reset unless the top is overridden
//   INSTR_W         : instruction word width
//   PC_INC          : byte distance between consecutive instructions
//   rsp_kind_e      : how an incoming memory response is disposed of
package instr_prefetch_pkg;

    localparam logic [31:0] PC_INIT_DEFAULT = 32'h0000_0100;
    localparam int unsigned INSTR_W         = 32;
    localparam int unsigned PC_INC          = 4;

    typedef enum logic [1:0] {
        RSP_NONE   = 2'd0,  // no response this cycle
        RSP_DROP   = 2'd1,  // response belongs to a squashed request
        RSP_FILL   = 2'd2,  // response fills the oldest live entry
        RSP_ORPHAN = 2'd3   // response with nothing outstanding (protocol error)
    } rsp_kind_e;

endpackage

// File: rtl/instr_prefetch_if.sv
// Bus bundle between the prefetch stage, instruction memory and decode.
//   redirect/redirect_pc          : restart fetch (from execute)
//   req_valid/req_addr/req_ready  : memory request handshake
//   rsp_valid/rsp_data            : in-order memory responses
//   out_valid/out_pc/out_npc/out_instr/out_ready : decode handshake
// modport master: the prefetch stage; modport slave: its environment.
interface instr_prefetch_if
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = INSTR_W
);

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_npc;
    logic [DATA_W-1:0] out_instr;
    logic              out_ready;

    modport master (
        input  redirect, redirect_pc,
        output req_valid, req_addr,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output out_valid, out_pc, out_npc, out_instr,
        input  out_ready
    );

    modport slave (
        output redirect, redirect_pc,
        input  req_valid, req_addr,
        output req_ready,
        output rsp_valid, rsp_data,
        input  out_valid, out_pc, out_npc, out_instr,
        output out_ready
    );

endinterface

// File: rtl/instr_prefetch_buf.sv
// DEPTH-entry prefetch register file.
//   clk, rst_n          : clock, synchronous active-low reset (full bits only)
//   clear               : drop every entry (redirect)
//   alloc_en/ptr/pc     : reserve an entry for an issued request, record its PC
//   fill_en/ptr/data    : store the returned instruction and mark the entry full
//   rd_en/rd_ptr        : consume the entry at rd_ptr
//   rd_full/rd_pc/rd_instr : contents of the entry at rd_ptr
//   full_vec            : per-entry full bits
module instr_prefetch_buf #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     alloc_en,
    input  logic [$clog2(DEPTH)-1:0] alloc_ptr,
    input  logic [ADDR_W-1:0]        alloc_pc,
    input  logic                     fill_en,
    input  logic [$clog2(DEPTH)-1:0] fill_ptr,
    input  logic [DATA_W-1:0]        fill_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic                     rd_full,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [DATA_W-1:0]        rd_instr,
    output logic [DEPTH-1:0]         full_vec
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [DEPTH-1:0]  full_q;

    // Payload needs no reset: an entry is only read once its full bit is set.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            pc_q[alloc_ptr] <= alloc_pc;
        end
        if (fill_en) begin
            instr_q[fill_ptr] <= fill_data;
        end
    end

    // Alloc, fill and read always target different entries in one cycle,
    // so the update order below never actually arbitrates.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            full_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (alloc_en && alloc_ptr == PTR_W'(i)) begin
                    full_q[i] <= 1'b0;
                end
                if (rd_en && rd_ptr == PTR_W'(i)) begin
                    full_q[i] <= 1'b0;
                end
                if (fill_en && fill_ptr == PTR_W'(i)) begin
                    full_q[i] <= 1'b1;
                end
            end
        end
    end

    assign rd_full  = full_q[rd_ptr];
    assign rd_pc    = pc_q[rd_ptr];
    assign rd_instr = instr_q[rd_ptr];
    assign full_vec = full_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue.
// Runs its own fetch PC, issues in-order memory requests, buffers the
// returned words with their PC and hands {pc, npc, instr} to decode.
// A redirect flushes the queue, restarts fetch at redirect_pc and squashes
// responses still owed for requests issued before it.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : instr_prefetch_if.master (redirect, memory req/rsp, decode out)
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter int unsigned       DATA_W  = INSTR_W,
    parameter int unsigned       DEPTH   = 4,
    parameter logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_INIT_DEFAULT)
) (
    input logic              clk,
    input logic              rst_n,
    instr_prefetch_if.master bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_prefetch: DEPTH must be a power of two, at least 2");
    end

    logic [ADDR_W-1:0] fpc, fpc_n;
    logic [PTR_W-1:0]  alloc_ptr, alloc_n;
    logic [PTR_W-1:0]  fill_ptr, fill_n;
    logic [PTR_W-1:0]  rd_ptr, rd_n;
    logic [CNT_W-1:0]  used, used_n;
    logic [CNT_W-1:0]  drop_cnt, drop_n;

    logic [DEPTH-1:0]  full_vec;
    logic [CNT_W-1:0]  full_cnt;
    logic [CNT_W-1:0]  pending;
    logic [CNT_W:0]    occupancy;
    rsp_kind_e         rsp_kind;

    logic              accept;
    logic              fill;
    logic              deq;
    logic              rd_full;
    logic [ADDR_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_instr;

    always_comb begin
        full_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            full_cnt = full_cnt + CNT_W'(full_vec[i]);
        end
    end

    // Allocated entries still waiting for their instruction word.
    assign pending   = used - full_cnt;
    // Slots spoken for: live entries plus squashed responses still owed.
    assign occupancy = {1'b0, used} + {1'b0, drop_cnt};

    // Squashed responses are older than any live request, so they are
    // consumed first.
    always_comb begin
        rsp_kind = RSP_NONE;
        if (bus.rsp_valid) begin
            if (drop_cnt != '0) begin
                rsp_kind = RSP_DROP;
            end else if (pending != '0) begin
                rsp_kind = RSP_FILL;
            end else begin
                rsp_kind = RSP_ORPHAN;
            end
        end
    end

    assign bus.req_valid = rst_n && !bus.redirect && (occupancy < (CNT_W + 1)'(DEPTH));
    assign bus.req_addr  = fpc;

    assign accept = bus.req_valid && bus.req_ready;
    assign fill   = (rsp_kind == RSP_FILL);
    assign deq    = rd_full && bus.out_ready && !bus.redirect;

    always_comb begin
        fpc_n   = fpc;
        alloc_n = alloc_ptr;
        fill_n  = fill_ptr;
        rd_n    = rd_ptr;
        used_n  = used;
        drop_n  = drop_cnt;
        if (bus.redirect) begin
            fpc_n   = bus.redirect_pc & ~ADDR_W'(3);
            alloc_n = '0;
            fill_n  = '0;
            rd_n    = '0;
            used_n  = '0;
            // Everything still owed by memory, less this cycle's response.
            drop_n  = drop_cnt + pending
                      - CNT_W'(rsp_kind == RSP_DROP || rsp_kind == RSP_FILL);
        end else begin
            if (accept) begin
                alloc_n = alloc_ptr + PTR_W'(1);
                fpc_n   = fpc + ADDR_W'(PC_INC);
            end
            if (fill) begin
                fill_n = fill_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_n = rd_ptr + PTR_W'(1);
            end
            if (rsp_kind == RSP_DROP) begin
                drop_n = drop_cnt - CNT_W'(1);
            end
            used_n = used + CNT_W'(accept) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc       <= PC_INIT;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            used      <= '0;
            drop_cnt  <= '0;
        end else begin
            fpc       <= fpc_n;
            alloc_ptr <= alloc_n;
            fill_ptr  <= fill_n;
            rd_ptr    <= rd_n;
            used      <= used_n;
            drop_cnt  <= drop_n;
        end
    end

    instr_prefetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (bus.redirect),
        .alloc_en  (accept),
        .alloc_ptr (alloc_ptr),
        .alloc_pc  (fpc),
        .fill_en   (fill),
        .fill_ptr  (fill_ptr),
        .fill_data (bus.rsp_data),
        .rd_en     (deq),
        .rd_ptr    (rd_ptr),
        .rd_full   (rd_full),
        .rd_pc     (rd_pc),
        .rd_instr  (rd_instr),
        .full_vec  (full_vec)
    );

    assign bus.out_valid = rd_full;
    assign bus.out_pc    = rd_pc;
    assign bus.out_npc   = rd_pc + ADDR_W'(PC_INC);
    assign bus.out_instr = rd_instr;

    // A response with nothing outstanding is ignored by the datapath.
    rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_kind != RSP_ORPHAN);

endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 4;
    localparam logic [31:0] PC_INIT = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_prefetch #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .PC_INIT (PC_INIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] rpc;   // redirect target driven
        logic [31:0] a0;    // first request address after redirect
        logic [31:0] a1;    // second request address after redirect
        logic [31:0] npc0;  // out_npc of the first delivered instruction
    } vec_t;

    int          errors;
    int          checks;
    int          cyc;
    int          epoch;
    int          arrived;       // live entries at the queue head that hold data
    logic [31:0] m_fpc;
    logic [31:0] exp_q [$];     // PCs issued since the last flush, not yet consumed
    mreq_t       mem_q [$];     // memory-side outstanding requests, in order

    int lat_min, lat_max, rdy_pct, ordy_pct, rsp_pct;

    logic        s_rv, s_ov;
    logic [31:0] s_addr, s_pc, s_npc, s_instr;

    vec_t tbl [5];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input logic redir, input logic [31:0] rpc);
        logic exp_rv, exp_ov, acc, deq, rsp;
        int   stale;
        @(negedge clk);
        rst_n           = 1'b1;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.req_ready   = ($urandom_range(99) < rdy_pct);
        bus.out_ready   = ($urandom_range(99) < ordy_pct);
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
        bus.rsp_valid   = rsp;
        bus.rsp_data    = rsp ? data_of(mem_q[0].addr) : $urandom;
        #1;
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
        exp_rv = !redir && (exp_q.size() + stale < DEPTH);
        exp_ov = (arrived > 0);
        s_rv = bus.req_valid;  s_addr = bus.req_addr;
        s_ov = bus.out_valid;  s_pc = bus.out_pc;
        s_npc = bus.out_npc;   s_instr = bus.out_instr;
        chk("req_valid", {31'd0, s_rv}, {31'd0, exp_rv});
        chk("req_addr", s_addr, m_fpc);
        chk("out_valid", {31'd0, s_ov}, {31'd0, exp_ov});
        if (exp_ov) begin
            chk("out_pc", s_pc, exp_q[0]);
            chk("out_npc", s_npc, exp_q[0] + 32'd4);
            chk("out_instr", s_instr, data_of(exp_q[0]));
        end
        acc = exp_rv && bus.req_ready;
        deq = exp_ov && bus.out_ready && !redir;
        if (rsp) begin
            if (mem_q[0].epoch == epoch) arrived++;
            void'(mem_q.pop_front());
        end
        if (redir) begin
            exp_q.delete();
            arrived = 0;
            epoch++;
            m_fpc = rpc & ~32'd3;
        end else begin
            if (deq) begin
                void'(exp_q.pop_front());
                arrived--;
            end
            if (acc) begin
                exp_q.push_back(m_fpc);
                mem_q.push_back('{addr: m_fpc, due: cyc + int'($urandom_range(lat_max, lat_min)), epoch: epoch});
                m_fpc = m_fpc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n         = 1'b0;
            bus.redirect  = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.req_ready = 1'b1;
            bus.out_ready = 1'b1;
            #1;
            chk("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
            if (i > 0) begin
                chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
                chk("rst_req_addr", bus.req_addr, PC_INIT);
            end
            cyc++;
        end
        // memory drops whatever it still owed
        m_fpc = PC_INIT;
        exp_q.delete();
        mem_q.delete();
        arrived = 0;
        epoch++;
    endtask

    task automatic knobs(input int lmin, input int lmax, input int rdy, input int ordy, input int rp);
        lat_min = lmin; lat_max = lmax; rdy_pct = rdy; ordy_pct = ordy; rsp_pct = rp;
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; epoch = 0; arrived = 0;
        m_fpc = PC_INIT;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0; bus.rsp_data = '0; bus.out_ready = 1'b0;

        tbl[0] = '{32'h0000_1003, 32'h0000_1000, 32'h0000_1004, 32'h0000_1004};
        tbl[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
        tbl[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
        tbl[3] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004};
        tbl[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004};

        // Streaming, latency 1, always ready
        knobs(1, 1, 100, 100, 100);
        do_reset(2);
        step(0, '0);
        chk("A_first_addr", s_addr, PC_INIT);
        step(0, '0);
        chk("A_c1_out_valid", {31'd0, s_ov}, 32'd0);
        step(0, '0);
        chk("A_c2_out_pc", s_pc, PC_INIT);
        step(0, '0);
        chk("A_c3_out_pc", s_pc, PC_INIT + 32'd4);
        chk("A_c3_out_npc", s_npc, PC_INIT + 32'd8);
        for (int i = 0; i < 6; i++) step(0, '0);

        // Decode stall fills the queue, then drains
        do_reset(1);
        knobs(1, 1, 100, 0, 100);
        for (int i = 0; i < 10; i++) step(0, '0);
        chk("B_stall_req_valid", {31'd0, s_rv}, 32'd0);
        chk("B_stall_out_pc", s_pc, PC_INIT);
        ordy_pct = 100;
        for (int i = 0; i < 4; i++) step(0, '0);
        chk("B_fourth_out_pc", s_pc, PC_INIT + 32'd12);
        for (int i = 0; i < 8; i++) step(0, '0);

        // Redirect with three requests in flight, latency 3
        do_reset(1);
        knobs(3, 3, 100, 100, 100);
        for (int i = 0; i < 3; i++) step(0, '0);
        rsp_pct = 0;
        step(1, 32'h0000_1000);
        rsp_pct = 100;
        step(0, '0);
        chk("C_req_valid", {31'd0, s_rv}, 32'd1);
        chk("C_req_addr", s_addr, 32'h0000_1000);
        for (int i = 0; i < 3; i++) step(0, '0);
        chk("C_no_stale", {31'd0, s_ov}, 32'd0);
        step(0, '0);
        chk("C_out_valid", {31'd0, s_ov}, 32'd1);
        chk("C_out_pc", s_pc, 32'h0000_1000);
        chk("C_out_instr", s_instr, data_of(32'h0000_1000));

        // Redirect coinciding with response and dequeue, latency 2
        knobs(2, 2, 100, 100, 100);
        for (int i = 0; i < 10; i++) step(0, '0);
        step(1, 32'h0000_2000);
        chk("D_deq_in_redirect", {31'd0, s_ov}, 32'd1);
        step(0, '0);
        chk("D_req_valid", {31'd0, s_rv}, 32'd1);
        chk("D_req_addr", s_addr, 32'h0000_2000);
        for (int i = 0; i < 3; i++) step(0, '0);
        chk("D_out_pc", s_pc, 32'h0000_2000);

        // Table: redirect targets incl. low-bit masking and address wrap
        knobs(1, 1, 100, 100, 100);
        for (int r = 0; r < 5; r++) begin
            step(0, '0);
            step(0, '0);
            step(1, tbl[r].rpc);
            step(0, '0);
            chk("T_a0", s_addr, tbl[r].a0);
            step(0, '0);
            chk("T_a1", s_addr, tbl[r].a1);
            step(0, '0);
            chk("T_out_valid", {31'd0, s_ov}, 32'd1);
            chk("T_out_pc", s_pc, tbl[r].a0);
            chk("T_out_npc", s_npc, tbl[r].npc0);
        end

        // One-cycle reset mid-stream
        for (int i = 0; i < 5; i++) step(0, '0);
        do_reset(1);
        step(0, '0);
        chk("F_out_valid", {31'd0, s_ov}, 32'd0);
        chk("F_req_addr", s_addr, PC_INIT);
        chk("F_req_valid", {31'd0, s_rv}, 32'd1);
        for (int i = 0; i < 4; i++) step(0, '0);

        // Randomised traffic against the model
        knobs(1, 2, 90, 90, 100);
        for (int i = 0; i < 800; i++)
            step($urandom_range(99) < 3, $urandom);
        knobs(1, 6, 70, 60, 80);
        for (int i = 0; i < 1200; i++)
            step($urandom_range(99) < 5, $urandom);
        knobs(3, 8, 50, 30, 60);
        for (int i = 0; i < 1000; i++)
            step($urandom_range(99) < 8, $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
